// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one carry-ripple segment per stage, valid/ready on both sides.
// Optional macro PIPE_ADDER_OVERFLOW_EN adds the registered signed-overflow output ovf.
module pipe_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPE_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic             w_stall;
    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff  = b ^ {WIDTH{sub}};
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added, right-justified: segment k sits in the low SEG bits.
        localparam int unsigned IW = WIDTH - k * SEG;

        logic [IW-1:0]        w_a_in;
        logic [IW-1:0]        w_b_in;
        logic                 w_c_in;
        logic                 w_v_in;
        logic [SEG:0]         w_seg;
        logic [(k+1)*SEG-1:0] w_sum_nxt;
        logic                 r_valid;
        logic                 r_carry;
        logic [(k+1)*SEG-1:0] r_sum;

        assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                     + {{SEG{1'b0}}, w_c_in};

        if (k == 0) begin : g_in
            assign w_a_in    = a;
            assign w_b_in    = w_b_eff;
            assign w_c_in    = cin ^ sub;
            assign w_v_in    = in_valid;
            assign w_sum_nxt = w_seg[SEG-1:0];
        end else begin : g_in
            assign w_a_in    = g_stage[k-1].g_fwd.r_a;
            assign w_b_in    = g_stage[k-1].g_fwd.r_b;
            assign w_c_in    = g_stage[k-1].r_carry;
            assign w_v_in    = g_stage[k-1].r_valid;
            assign w_sum_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (!w_stall) begin
                r_valid <= w_v_in;
                r_carry <= w_seg[SEG];
                r_sum   <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SEG-1:0] r_a;
            logic [IW-SEG-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a_in[IW-1:SEG];
                    r_b <= w_b_in[IW-1:SEG];
                end
            end
        end

`ifdef PIPE_ADDER_OVERFLOW_EN
        // The last segment still holds the operand sign bits, so overflow is resolved here.
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= (w_a_in[SEG-1] == w_b_in[SEG-1]) && (w_seg[SEG-1] != w_a_in[SEG-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
`ifdef PIPE_ADDER_OVERFLOW_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
